// File: rtl/zx_mem_pager.sv
// zx_mem_pager: 128K/+2A-style memory paging unit for the ZX Spectrum host.
// Latches the 0x7FFD / 0x1FFD paging ports from CPU I/O writes and maps each
// CPU address onto a ROM page or a physical RAM bank plus 14-bit offset.
module zx_mem_pager #(
    parameter int RAM_BANKS = 8,
    parameter int ROM_PAGES = 2,
    parameter int PLUS3     = 0,
    localparam int BANKW    = $clog2(RAM_BANKS),
    localparam int ROMW     = $clog2(ROM_PAGES)
) (
    input  logic               clk_cpu,
    input  logic               reset,
    input  logic [15:0]        A,
    input  logic [7:0]         D,
    input  logic               nIORQ,
    input  logic               nMREQ,
    input  logic               nRD,
    input  logic               nWR,
    input  logic               nM1,
    input  logic               mode48,
    output logic               is_rom,
    output logic [ROMW-1:0]    rom_page,
    output logic [BANKW-1:0]   ram_bank,
    output logic [BANKW+13:0]  phys_addr,
    output logic               ram_we,
    output logic               screen_bank,
    output logic               paging_locked,
    output logic [7:0]         port_7ffd,
    output logic [7:0]         port_1ffd
);

    logic [7:0]       r7ffd;
    logic [7:0]       r1ffd;
    logic             wr_q;
    logic             io_wr;
    logic             sel_7ffd;
    logic             sel_1ffd;
    logic             commit;
    logic             special;
    logic             is_rom_slot;
    logic [BANKW-1:0] bank_c;
    logic [2:0]       special_bank;

    // Bus decode: I/O write strobe and exclusive paging-port address decode
    always_comb begin
        io_wr = !nIORQ && !nWR && nM1;
        if (PLUS3 != 0) begin
            sel_7ffd = (A[15:14] == 2'b01) && !A[1];
            sel_1ffd = (A[15:12] == 4'b0001) && !A[1];
        end else begin
            sel_7ffd = !A[15] && !A[1];
            sel_1ffd = 1'b0;
        end
        // Only the first cycle of a held write may commit; lock and 48K mode block it
        commit = io_wr && !wr_q && !r7ffd[5] && !mode48;
    end

    // Paging registers and write-edge tracker; reset wins over a same-cycle commit
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            r7ffd <= '0;
            r1ffd <= '0;
            wr_q  <= 1'b1;
        end else begin
            wr_q <= io_wr;
            if (commit && sel_7ffd)
                r7ffd <= D;
            if (commit && sel_1ffd)
                r1ffd <= D;
        end
    end

    // Address translation: normal/special slot map, ROM page, write enable
    always_comb begin
        bank_c  = mode48 ? '0 : BANKW'({r7ffd[7:6], r7ffd[2:0]});
        special = (PLUS3 != 0) && r1ffd[0] && !mode48;

        case ({r1ffd[2:1], A[15:14]})
            4'b00_00: special_bank = 3'd0;
            4'b00_01: special_bank = 3'd1;
            4'b00_10: special_bank = 3'd2;
            4'b00_11: special_bank = 3'd3;
            4'b01_00: special_bank = 3'd4;
            4'b01_01: special_bank = 3'd5;
            4'b01_10: special_bank = 3'd6;
            4'b01_11: special_bank = 3'd7;
            4'b10_00: special_bank = 3'd4;
            4'b10_01: special_bank = 3'd5;
            4'b10_10: special_bank = 3'd6;
            4'b10_11: special_bank = 3'd3;
            4'b11_00: special_bank = 3'd4;
            4'b11_01: special_bank = 3'd7;
            4'b11_10: special_bank = 3'd6;
            default:  special_bank = 3'd3;
        endcase

        is_rom_slot = 1'b0;
        if (special) begin
            ram_bank = BANKW'(special_bank);
        end else begin
            case (A[15:14])
                2'b00: begin
                    ram_bank    = '0;
                    is_rom_slot = 1'b1;
                end
                2'b01:   ram_bank = BANKW'(5);
                2'b10:   ram_bank = BANKW'(2);
                default: ram_bank = bank_c;
            endcase
        end

        phys_addr     = {ram_bank, A[13:0]};
        is_rom        = !nMREQ && is_rom_slot;
        ram_we        = !nMREQ && !nWR && nRD && !is_rom_slot;
        rom_page      = mode48 ? ROMW'(ROM_PAGES - 1) : ROMW'({r1ffd[2], r7ffd[4]});
        screen_bank   = !mode48 && r7ffd[3];
        paging_locked = r7ffd[5];
        port_7ffd     = r7ffd;
        port_1ffd     = (PLUS3 != 0) ? r1ffd : 8'h00;
    end

endmodule

// File: tb/tb_zx_mem_pager.sv
// Directed self-checking bench for zx_mem_pager: a default 48K/128K instance
// and a 32-bank, 4-page +2A instance share one CPU bus.
module tb_zx_mem_pager;

    logic        clk;
    logic        reset;
    logic [15:0] A;
    logic [7:0]  D;
    logic        nIORQ, nMREQ, nRD, nWR, nM1, mode48;

    logic        a_is_rom, a_ram_we, a_screen, a_locked;
    logic [0:0]  a_rom_page;
    logic [2:0]  a_bank;
    logic [16:0] a_phys;
    logic [7:0]  a_7ffd, a_1ffd;

    logic        b_is_rom, b_ram_we, b_screen, b_locked;
    logic [1:0]  b_rom_page;
    logic [4:0]  b_bank;
    logic [18:0] b_phys;
    logic [7:0]  b_7ffd, b_1ffd;

    int checks = 0;
    int errors = 0;

    zx_mem_pager u_dut8 (
        .clk_cpu(clk), .reset(reset), .A(A), .D(D),
        .nIORQ(nIORQ), .nMREQ(nMREQ), .nRD(nRD), .nWR(nWR), .nM1(nM1),
        .mode48(mode48),
        .is_rom(a_is_rom), .rom_page(a_rom_page), .ram_bank(a_bank),
        .phys_addr(a_phys), .ram_we(a_ram_we), .screen_bank(a_screen),
        .paging_locked(a_locked), .port_7ffd(a_7ffd), .port_1ffd(a_1ffd)
    );

    zx_mem_pager #(.RAM_BANKS(32), .ROM_PAGES(4), .PLUS3(1)) u_dut32 (
        .clk_cpu(clk), .reset(reset), .A(A), .D(D),
        .nIORQ(nIORQ), .nMREQ(nMREQ), .nRD(nRD), .nWR(nWR), .nM1(nM1),
        .mode48(mode48),
        .is_rom(b_is_rom), .rom_page(b_rom_page), .ram_bank(b_bank),
        .phys_addr(b_phys), .ram_we(b_ram_we), .screen_bank(b_screen),
        .paging_locked(b_locked), .port_7ffd(b_7ffd), .port_1ffd(b_1ffd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        nIORQ = 1'b1; nMREQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nM1 = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic io_write(input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk);
        A = addr; D = data; nIORQ = 1'b0; nWR = 1'b0;
        @(negedge clk);
        idle();
        @(negedge clk);
    endtask

    // Memory cycle on the bus; wr=1 is a write, wr=0 a read
    task automatic mem(input logic [15:0] addr, input logic wr);
        A = addr; nIORQ = 1'b1; nMREQ = 1'b0; nRD = wr; nWR = !wr;
        #1;
    endtask

    initial begin
        A = 16'h0000; D = 8'h00; mode48 = 1'b0; reset = 1'b1;
        idle();
        do_reset();

        // Reset state
        check("rst_7ffd", a_7ffd, 8'h00);
        check("rst_1ffd_a", a_1ffd, 8'h00);
        check("rst_1ffd_b", b_1ffd, 8'h00);
        check("rst_locked", a_locked, 1'b0);
        check("rst_screen", a_screen, 1'b0);
        mem(16'h0123, 1'b0);
        check("rst_is_rom", a_is_rom, 1'b1);
        check("rst_rom_page", a_rom_page, 1'b0);
        mem(16'h4000, 1'b0);
        check("rst_bank_4000", a_bank, 3'd5);
        check("rst_is_rom_4000", a_is_rom, 1'b0);
        mem(16'h8000, 1'b0);
        check("rst_bank_8000", a_bank, 3'd2);
        mem(16'hC000, 1'b0);
        check("rst_bank_c000", a_bank, 3'd0);
        idle();

        // OUT (0x7FFD),0x13
        io_write(16'h7FFD, 8'h13);
        mem(16'hC005, 1'b0);
        check("p13_bank", a_bank, 3'd3);
        check("p13_phys", a_phys, 17'h0C005);
        check("p13_rom_page", a_rom_page, 1'b1);
        check("p13_screen", a_screen, 1'b0);
        mem(16'hC005, 1'b1);
        check("p13_we_ram", a_ram_we, 1'b1);
        mem(16'h1000, 1'b1);
        check("p13_we_rom", a_ram_we, 1'b0);
        idle();

        // Non-paging port write and interrupt-acknowledge cycle leave state alone
        io_write(16'h00FF, 8'h55);
        check("nonport_7ffd", a_7ffd, 8'h13);
        @(negedge clk);
        A = 16'h7FFD; D = 8'h66; nIORQ = 1'b0; nWR = 1'b0; nM1 = 1'b0;
        @(negedge clk);
        idle();
        @(negedge clk);
        check("m1_7ffd", a_7ffd, 8'h13);

        // Held write commits once
        A = 16'h7FFD; D = 8'h02; nIORQ = 1'b0; nWR = 1'b0;
        repeat (5) @(negedge clk);
        check("hold_first", a_7ffd, 8'h02);
        D = 8'h04;
        repeat (2) @(negedge clk);
        check("hold_changed", a_7ffd, 8'h02);
        idle();
        @(negedge clk);
        check("hold_release", a_7ffd, 8'h02);

        // Lock
        io_write(16'h7FFD, 8'h27);
        check("lock_7ffd", a_7ffd, 8'h27);
        check("lock_bit", a_locked, 1'b1);
        io_write(16'h7FFD, 8'h01);
        check("locked_7ffd", a_7ffd, 8'h27);
        mem(16'hC000, 1'b0);
        check("locked_bank", a_bank, 3'd7);
        idle();

        // mode48
        do_reset();
        check("reset_unlock", a_locked, 1'b0);
        io_write(16'h7FFD, 8'h1F);
        check("m48_pre_screen", b_screen, 1'b1);
        check("m48_pre_rom", b_rom_page, 2'd1);
        mode48 = 1'b1;
        mem(16'hC000, 1'b0);
        check("m48_bank", b_bank, 5'd0);
        check("m48_bank_a", a_bank, 3'd0);
        check("m48_rom", b_rom_page, 2'd3);
        check("m48_screen", b_screen, 1'b0);
        check("m48_keep", b_7ffd, 8'h1F);
        idle();
        io_write(16'h7FFD, 8'h00);
        check("m48_ignored", b_7ffd, 8'h1F);
        @(negedge clk);
        A = 16'h7FFD; D = 8'h00; nIORQ = 1'b0; nWR = 1'b0;
        @(negedge clk);
        mode48 = 1'b0;
        @(negedge clk);
        idle();
        @(negedge clk);
        check("m48_drop_lost", b_7ffd, 8'h1F);
        check("m48_off_screen", b_screen, 1'b1);
        mem(16'hC000, 1'b0);
        check("m48_off_bank", b_bank, 5'd7);
        idle();

        // +2A special paging
        do_reset();
        io_write(16'h1FFD, 8'h07);
        check("sp7_1ffd", b_1ffd, 8'h07);
        check("sp7_1ffd_nop3", a_1ffd, 8'h00);
        mem(16'h0000, 1'b0);
        check("sp7_is_rom", b_is_rom, 1'b0);
        check("sp7_bank_0000", b_bank, 5'd4);
        mem(16'h4000, 1'b0);
        check("sp7_bank_4000", b_bank, 5'd7);
        mem(16'h8000, 1'b0);
        check("sp7_bank_8000", b_bank, 5'd6);
        mem(16'hC000, 1'b0);
        check("sp7_bank_c000", b_bank, 5'd3);
        mem(16'h0000, 1'b1);
        check("sp7_we_slot0", b_ram_we, 1'b1);
        idle();
        io_write(16'h1FFD, 8'h05);
        mem(16'h4000, 1'b0);
        check("sp5_bank_4000", b_bank, 5'd5);
        mem(16'hC000, 1'b0);
        check("sp5_bank_c000", b_bank, 5'd3);
        idle();
        io_write(16'h1FFD, 8'h01);
        mem(16'h0000, 1'b0);
        check("sp1_bank_0000", b_bank, 5'd0);
        mem(16'h4000, 1'b0);
        check("sp1_bank_4000", b_bank, 5'd1);
        idle();
        io_write(16'h1FFD, 8'h04);
        mem(16'h0000, 1'b0);
        check("rom_hi_is_rom", b_is_rom, 1'b1);
        check("rom_hi_page", b_rom_page, 2'd2);
        idle();
        io_write(16'h3FFD, 8'h10);
        check("dec_p3_7ffd", b_7ffd, 8'h00);
        check("dec_48_7ffd", a_7ffd, 8'h10);

        // 32 banks
        do_reset();
        io_write(16'h7FFD, 8'hC6);
        mem(16'hC000, 1'b0);
        check("b32_bank", b_bank, 5'h1E);
        check("b32_phys", b_phys, 19'h78000);
        check("b8_bank", a_bank, 3'd6);
        mem(16'h1000, 1'b1);
        check("b32_we_rom", b_ram_we, 1'b0);
        mem(16'hC000, 1'b1);
        check("b32_we_ram", b_ram_we, 1'b1);
        idle();
        io_write(16'h1FFD, 8'h04);
        check("b32_1ffd", b_1ffd, 8'h04);

        // Reset in the middle of a write
        @(negedge clk);
        A = 16'h7FFD; D = 8'h18; nIORQ = 1'b0; nWR = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("rmw_7ffd", b_7ffd, 8'h00);
        check("rmw_1ffd", b_1ffd, 8'h00);
        reset = 1'b0;
        @(negedge clk);
        check("rmw_held_7ffd", b_7ffd, 8'h00);
        idle();
        @(negedge clk);
        check("rmw_after_7ffd", b_7ffd, 8'h00);
        check("rmw_after_a", a_7ffd, 8'h00);
        check("rmw_locked", b_locked, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
